// File: rtl/micro80_pkg.sv
// Shared definitions for the Micro80 CPU to SDRAM word bridge:
// bridge state encoding, strobe idle level and controller bus widths.
package micro80_pkg;

  localparam int SDRAM_AW = 24;
  localparam int SDRAM_DW = 16;

  // Controller strobes are active-low, so "idle" is a high level.
  localparam logic STROBE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RREQ  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_MERGE = 3'd4,
    ST_WREQ  = 3'd5,
    ST_WWAIT = 3'd6,
    ST_ACK   = 3'd7
  } state_t;

  function automatic logic [7:0] sel_byte(input logic [SDRAM_DW-1:0] word,
                                          input logic                hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/byte_merge.sv
// Replaces one byte lane of a 16-bit word with a new byte.
// hi_i = 1 selects the upper lane [15:8].
module byte_merge (
  input  logic [15:0] word_i,
  input  logic [7:0]  byte_i,
  input  logic        hi_i,
  output logic [15:0] word_o
);

  assign word_o = hi_i ? {byte_i, word_i[7:0]} : {word_i[15:8], byte_i};

endmodule

// File: rtl/sdram_byte_bridge.sv
// Micro80 8-bit bus to 16-bit SDRAM controller bridge with a one-word
// read/write-through buffer and read-modify-write for byte stores.
module sdram_byte_bridge
  import micro80_pkg::*;
#(
  parameter logic [8:0] PAGE   = 9'h000,
  parameter bit         BUF_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         cpu_addr,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [7:0]          cpu_din,
  output logic [7:0]          cpu_dout,
  output logic                cpu_ready,
  output logic                mem_rd_n,
  output logic                mem_wr_n,
  output logic [SDRAM_AW-1:0] mem_add,
  output logic [SDRAM_DW-1:0] mem_di,
  input  logic [SDRAM_DW-1:0] mem_do,
  input  logic                mem_rdy
);

  state_t                state_q;
  logic                  arm_q;
  logic                  rmw_q;
  logic                  buf_v_q;
  logic [14:0]           buf_tag_q;
  logic [SDRAM_DW-1:0]   buf_data_q;
  logic [7:0]            cpu_dout_q;
  logic                  cpu_ready_q;
  logic                  mem_rd_n_q;
  logic                  mem_wr_n_q;
  logic [SDRAM_AW-1:0]   mem_add_q;
  logic [SDRAM_DW-1:0]   mem_di_q;

  logic [14:0]           word_sel;
  logic                  lane_hi;
  logic                  buf_hit;
  logic [SDRAM_DW-1:0]   merged_word;

  assign word_sel = cpu_addr[15:1];
  assign lane_hi  = cpu_addr[0];
  assign buf_hit  = BUF_EN && buf_v_q && (buf_tag_q == word_sel);

  // One merger serves both the write-hit path (IDLE) and MERGE, since both
  // patch the current buffer word with the CPU byte.
  byte_merge u_byte_merge (
    .word_i (buf_data_q),
    .byte_i (cpu_din),
    .hi_i   (lane_hi),
    .word_o (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      arm_q       <= 1'b0;
      rmw_q       <= 1'b0;
      buf_v_q     <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      cpu_dout_q  <= 8'h00;
      cpu_ready_q <= 1'b0;
      mem_rd_n_q  <= STROBE_IDLE;
      mem_wr_n_q  <= STROBE_IDLE;
      mem_add_q   <= '0;
      mem_di_q    <= '0;
    end else begin
      cpu_ready_q <= 1'b0;

      case (state_q)
        ST_INIT: begin
          if (mem_rdy) state_q <= ST_IDLE;
        end

        ST_IDLE: begin
          if (arm_q && cpu_wr) begin
            mem_add_q <= {PAGE, word_sel};
            if (buf_hit) begin
              buf_data_q <= merged_word;
              mem_di_q   <= merged_word;
              state_q    <= ST_WREQ;
            end else begin
              rmw_q   <= 1'b1;
              state_q <= ST_RREQ;
            end
          end else if (arm_q && cpu_rd) begin
            if (buf_hit) begin
              cpu_dout_q  <= sel_byte(buf_data_q, lane_hi);
              cpu_ready_q <= 1'b1;
              state_q     <= ST_ACK;
            end else begin
              rmw_q     <= 1'b0;
              mem_add_q <= {PAGE, word_sel};
              state_q   <= ST_RREQ;
            end
          end
        end

        // Only leave once our own strobe has been seen by a busy controller.
        ST_RREQ: begin
          if (!mem_rd_n_q && !mem_rdy) begin
            mem_rd_n_q <= STROBE_IDLE;
            state_q    <= ST_RWAIT;
          end else if (mem_rdy) begin
            mem_rd_n_q <= 1'b0;
          end
        end

        ST_RWAIT: begin
          if (mem_rdy) begin
            buf_data_q <= mem_do;
            buf_tag_q  <= mem_add_q[14:0];
            buf_v_q    <= 1'b1;
            if (rmw_q) begin
              state_q <= ST_MERGE;
            end else begin
              cpu_dout_q  <= sel_byte(mem_do, lane_hi);
              cpu_ready_q <= 1'b1;
              state_q     <= ST_ACK;
            end
          end
        end

        ST_MERGE: begin
          buf_data_q <= merged_word;
          mem_di_q   <= merged_word;
          state_q    <= ST_WREQ;
        end

        ST_WREQ: begin
          if (!mem_wr_n_q && !mem_rdy) begin
            mem_wr_n_q <= STROBE_IDLE;
            state_q    <= ST_WWAIT;
          end else if (mem_rdy) begin
            mem_wr_n_q <= 1'b0;
          end
        end

        ST_WWAIT: begin
          if (mem_rdy) begin
            cpu_ready_q <= 1'b1;
            state_q     <= ST_ACK;
          end
        end

        ST_ACK: begin
          arm_q   <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_INIT;
      endcase

      // NOTE: this non-blocking assignment comes after the case on purpose;
      // the last NBA to arm_q wins, so an idle bus re-arms even during ACK.
      if (!cpu_rd && !cpu_wr) arm_q <= 1'b1;
    end
  end

  assign cpu_dout  = cpu_dout_q;
  assign cpu_ready = cpu_ready_q;
  assign mem_rd_n  = mem_rd_n_q;
  assign mem_wr_n  = mem_wr_n_q;
  assign mem_add   = mem_add_q;
  assign mem_di    = mem_di_q;

endmodule

// File: doc/sdram_byte_bridge.md
# sdram_byte_bridge

Adapts the Micro80 8-bit CPU bus to the 16-bit word interface of the SDRAM controller. It maps byte reads and writes onto word transactions and performs read-modify-write for byte writes, because byte masks are not used. A one-word read/write-through buffer lets repeated accesses to the same word skip SDRAM. The bridge stretches CPU cycles through `cpu_ready`.

## Interface
- `PAGE`, default 9'h000: upper 9 bits of the 24-bit SDRAM word address. `mem_add` = {PAGE, cpu_addr[15:1]}.
- `BUF_EN`, default 1: 1 enables the word buffer; 0 sends every access to SDRAM.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `cpu_addr`  in  16: byte address. Bit 0 = 0 selects the low byte [7:0].
- `cpu_rd`  in  1: read request, level, active-high. Held until `cpu_ready`.
- `cpu_wr`  in  1: write request, level, active-high. Held until `cpu_ready`.
- `cpu_din`  in  8: write data.
- `cpu_dout`  out  8: read data.
- `cpu_ready`  out  1: one-cycle completion pulse.
- `mem_rd_n`  out  1: controller read strobe, active-low.
- `mem_wr_n`  out  1: controller write strobe, active-low.
- `mem_add`  out  24: word address to the controller.
- `mem_di`  out  16: write word to the controller.
- `mem_do`  in  16: read word from the controller.
- `mem_rdy`  in  1: controller idle/done, high = idle.

## Operation
- Memory contract: `mem_rdy` high means idle. A strobe seen low while idle starts exactly one transaction, and `mem_rdy` falls within 3 clocks. When `mem_rdy` rises again the transaction is complete and `mem_do` is valid.
- The bridge holds a strobe low from its REQ state until it sees `mem_rdy` low, then releases it. It never drives both strobes low at once.
- Word buffer contents: `buf_data[15:0]`, `buf_tag[14:0]` (= cpu_addr[15:1]), `buf_v`.
- Hit: `BUF_EN` = 1, `buf_v` = 1 and tag matches.
- States:
  - INIT: wait for first `mem_rdy` = 1 (controller init done), then IDLE.
  - IDLE: act on a request only if `arm` = 1.
    - Write takes priority over read when `cpu_rd` and `cpu_wr` are both high.
    - Read hit → ACK with the selected byte.
    - Read miss → RREQ.
    - Write hit → merge `cpu_din` into the buffer → WREQ.
    - Write miss → RREQ with the `rmw` flag set.
  - RREQ: if `mem_rdy` = 1, drive `mem_rd_n` = 0; on `mem_rdy` = 0 → RWAIT.
  - RWAIT: on `mem_rdy` = 1, load `buf_data` ← `mem_do`, set tag and `buf_v` ← 1. Go to MERGE if `rmw`, else ACK.
  - MERGE: replace the addressed byte with `cpu_din` → WREQ.
  - WREQ: `mem_di` = `buf_data`; drive `mem_wr_n` = 0 while `mem_rdy` = 1; on `mem_rdy` = 0 → WWAIT.
  - WWAIT: on `mem_rdy` = 1 → ACK.
  - ACK: `cpu_ready` = 1 for one cycle; `arm` ← 0 → IDLE.
- `arm` is set whenever `cpu_rd` and `cpu_wr` are both sampled low. A level request is therefore serviced once.
- `cpu_dout` is registered. It updates only in the ACK cycle of a read and holds otherwise.
- `rst` mid-transaction:
  - All outputs go to reset values immediately; the state returns to INIT.
  - `buf_v` ← 0.
  - An in-flight SDRAM transaction completes unobserved.
  - INIT waits for `mem_rdy` = 1 before accepting requests.

## Timing
- Reset values:
  - `cpu_ready` = 0, `cpu_dout` = 8'h00.
  - `mem_rd_n` = 1, `mem_wr_n` = 1.
  - `mem_add` = 0, `mem_di` = 0.
  - `buf_v` = 0, `arm` = 0, state = INIT.
- Read hit: request sampled in cycle N → `cpu_ready` and `cpu_dout` in N+1.
- Miss or write: latency = strobe acceptance + controller busy time + 1 (ACK).
- Read-modify-write adds 1 (MERGE) + one full write transaction.
- `mem_add` is stable from entry to RREQ/WREQ until the matching wait state exits.
- `mem_di` is stable throughout WREQ/WWAIT.
- Address wrap: cpu_addr 16'hFFFF maps to word {PAGE, 15'h7FFF}, high byte. No carry into PAGE.

## Structure
- Shared package `micro80_pkg`:
  - state encoding constants;
  - the active-low strobe idle value;
  - `SDRAM_AW` = 24 and `SDRAM_DW` = 16.
- The state machine and handshake are in the top module.
- Sub-module `byte_merge`: combinational 16-bit word, 8-bit byte and lane select → merged word. Used by both the write-hit path and MERGE.

## Test plan
- Reset released, `mem_rdy` held 0 for 50 cycles, then 1 → no strobe before `mem_rdy` = 1. Then read 16'h0001 with `mem_do` = 16'hA55A → `cpu_dout` = 8'hA5, one `mem_rd_n` pulse, `mem_add` = 24'h000000.
- Read 16'h0000 immediately after → hit: `cpu_ready` one cycle after the request, `cpu_dout` = 8'h5A, no strobe.
- Write 8'h3C to 16'h1235 (miss, memory word 16'h1122) → one read, then `mem_wr_n` with `mem_di` = 16'h3C22 at `mem_add` = 24'h00091A.
- Write 8'h77 to 16'h1234 (hit) → no read; single write with `mem_di` = 16'h3C77.
- `cpu_rd` held high for 20 cycles after `cpu_ready` → exactly one transaction. `cpu_rd` and `cpu_wr` both high → write performed.
- `rst` pulsed during RWAIT → outputs reset; next read of the same address misses and reissues `mem_rd_n`. With `PAGE` = 9'h1FF, address 16'hFFFF → `mem_add` = 24'hFFFFFF.
